// File: rtl/inv_pkg.sv
// Shared definitions for the inverter checker: FSM state encodings,
// default word width / FIFO depth, counter width and a saturating increment.
// No ports; imported by the interface, the FIFO and the top.
package inv_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/inv_checker_if.sv
// Bundle of control, stimulus, response and result signals of inv_checker.
// master: drives start/num_checks/stim_*/resp_*, observes the results.
// slave : the checker side, the reverse directions.
interface inv_checker_if import inv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [CNT_W-1:0] num_checks;
  logic             stim_valid;
  logic [WIDTH-1:0] stim_data;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             err;
  logic             ovf;
  logic             udf;
  logic [WIDTH-1:0] first_exp;
  logic [WIDTH-1:0] first_got;

  modport master (
    output start, num_checks, stim_valid, stim_data, resp_valid, resp_data,
    input  busy, done, pass_cnt, fail_cnt, err, ovf, udf, first_exp, first_got
  );

  modport slave (
    input  start, num_checks, stim_valid, stim_data, resp_valid, resp_data,
    output busy, done, pass_cnt, fail_cnt, err, ovf, udf, first_exp, first_got
  );

endinterface

// File: rtl/inv_exp_fifo.sv
// Expected-value FIFO: stores words in a register array, head word read from
// the array at the read pointer. DEPTH must be a power of two, at least 2.
// Ports: i_clk, i_rst (sync, high), i_clr (sync clear), i_push/i_dat,
// i_pop, o_dat (head), o_full, o_empty.
module inv_exp_fifo import inv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dat   = r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle; when full, write and read hit the same slot, and the head
  // is consumed from the old contents before the write lands.
  assign w_do_push = i_push && (!o_full || i_pop);
  // A pop on empty is refused even if a push arrives the same cycle.
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/inv_checker.sv
// Checks an inverter: stores ~stim_data in order, compares each response
// against the oldest stored word, counts pass/fail, flags FIFO misuse.
// Ports: i_clk, i_rst (sync, high), bus (inv_checker_if.slave).
module inv_checker import inv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         i_clk,
  input  logic         i_rst,
  inv_checker_if.slave bus
);

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic             r_err;
  logic             r_ovf;
  logic             r_udf;
  logic [WIDTH-1:0] r_first_exp;
  logic [WIDTH-1:0] r_first_got;

  logic             w_busy;
  logic             w_done;
  logic             w_run;
  logic             w_start_acc;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_head;
  logic             w_cmp_vld;
  logic             w_match;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic [CNT_W-1:0] w_pass_nxt;
  logic [CNT_W-1:0] w_fail_nxt;
  logic [CNT_W:0]   w_sum_nxt;
  logic             w_reached;

  assign w_run       = (r_state == ST_RUN);
  assign w_start_acc = bus.start && (r_state != ST_RUN);
  assign w_push      = w_run && bus.stim_valid;
  assign w_pop       = w_run && bus.resp_valid;

  inv_exp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start_acc),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (~bus.stim_data),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A comparison only happens when there is a real head word to compare.
  assign w_cmp_vld = w_pop && !w_empty;
  assign w_match   = (w_head == bus.resp_data);
  assign w_ovf_evt = w_push && w_full && !w_pop;
  assign w_udf_evt = w_pop && w_empty;

  assign w_pass_nxt = (w_cmp_vld && w_match)  ? sat_inc(r_pass) : r_pass;
  assign w_fail_nxt = (w_cmp_vld && !w_match) ? sat_inc(r_fail) : r_fail;

  // Completion looks at the counts this edge will write, so the run ends on
  // the same edge as its last comparison; a zero-length run ends at once.
  assign w_sum_nxt = {1'b0, w_pass_nxt} + {1'b0, w_fail_nxt};
  assign w_reached = (w_sum_nxt >= {1'b0, r_num});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_reached) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (bus.start) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_num       <= '0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else if (w_start_acc) begin
      r_num       <= bus.num_checks;
      r_pass      <= '0;
      r_fail      <= '0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else if (w_run) begin
      r_pass <= w_pass_nxt;
      r_fail <= w_fail_nxt;
      if (w_cmp_vld && !w_match) begin
        r_err <= 1'b1;
        // fail count is still zero only for the first mismatch of the run
        if (r_fail == '0) begin
          r_first_exp <= w_head;
          r_first_got <= bus.resp_data;
        end
      end
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
        r_err <= 1'b1;
      end
      if (w_udf_evt) begin
        r_udf <= 1'b1;
        r_err <= 1'b1;
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.pass_cnt  = r_pass;
  assign bus.fail_cnt  = r_fail;
  assign bus.err       = r_err;
  assign bus.ovf       = r_ovf;
  assign bus.udf       = r_udf;
  assign bus.first_exp = r_first_exp;
  assign bus.first_got = r_first_got;

endmodule

// File: doc/inv_checker.md
INV_CHECKER -- requirements
Module: inv_checker

Interface
REQ-001 Parameter WIDTH, default 8: data width of stimulus and response words.
REQ-002 Parameter DEPTH, default 4: expected-value FIFO depth; power of two, minimum 2.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 start  input  1: one-cycle pulse that begins a check run.
REQ-006 num_checks  input  16: number of comparisons in a run; sampled when start is accepted.
REQ-007 stim_valid  input  1: stim_data is a word applied to the inverter this cycle.
REQ-008 stim_data  input  WIDTH: stimulus word.
REQ-009 resp_valid  input  1: resp_data is the inverter output for the oldest outstanding stimulus.
REQ-010 resp_data  input  WIDTH: response word.
REQ-011 busy  output  1: high in RUN.
REQ-012 done  output  1: high in DONE.
REQ-013 pass_cnt  output  16: count of matching comparisons.
REQ-014 fail_cnt  output  16: count of mismatching comparisons.
REQ-015 err  output  1: sticky flag for any mismatch, overflow or underflow in the current run.
REQ-016 ovf  output  1: sticky flag for a push attempted while the FIFO is full.
REQ-017 udf  output  1: sticky flag for a pop attempted while the FIFO is empty.
REQ-018 first_exp  output  WIDTH: expected word at the first mismatch.
REQ-019 first_got  output  WIDTH: received word at the first mismatch.

Function
REQ-020 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-021 IDLE -> RUN SHALL occur on start; on that edge all counters, flags, first_* and the FIFO are cleared, and num_checks is latched.
REQ-022 RUN -> DONE SHALL occur on the edge where pass_cnt+fail_cnt reaches the latched num_checks.
REQ-023 If the latched num_checks is 0, RUN -> DONE SHALL occur on the next edge.
REQ-024 DONE -> RUN SHALL occur on start, with the same clearing as REQ-021.
REQ-025 Start SHALL be ignored in RUN.
REQ-026 Stim_valid and resp_valid SHALL be ignored outside RUN.
REQ-027 In RUN, stim_valid SHALL push ~stim_data (bitwise inverse) into the FIFO.
REQ-028 In RUN, resp_valid SHALL pop the FIFO head and compare it with resp_data.
REQ-029 Counters and flags SHALL update on the edge following the resp_valid cycle (registered, latency 1).
REQ-030 On a match, pass_cnt SHALL increment; on a mismatch, fail_cnt SHALL increment and err SHALL be set.
REQ-031 On the first mismatch of a run only, first_exp and first_got SHALL be captured.
REQ-032 Simultaneous push and pop with a full FIFO SHALL be legal: occupancy is unchanged and ovf is not set.
REQ-033 A push on a full FIFO without a pop SHALL drop the word and set ovf and err.
REQ-034 A pop on an empty FIFO SHALL set udf and err, change no counter, and use no bypass, even if a push occurs the same cycle; that push is still stored.
REQ-035 pass_cnt and fail_cnt SHALL saturate at 16'hFFFF.
REQ-036 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked in a log2(DEPTH)+1-bit count.
REQ-037 Results SHALL hold stable in DONE until the next start.

Reset
REQ-038 rst SHALL force IDLE and clear the FIFO pointers and count.
REQ-039 rst SHALL set busy=0, done=0, pass_cnt=0, fail_cnt=0, err=0, ovf=0, udf=0, first_exp=0 and first_got=0.
REQ-040 rst asserted mid-run SHALL abort the run with the same values on the next edge; rst takes priority over start.

Structure
REQ-041 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH/DEPTH SHALL live in a shared include/package inv_pkg.
REQ-042 The FIFO SHALL be a separate sub-module, inv_exp_fifo: push/pop/full/empty, data out registered at the head.

Verification
REQ-043 Reset then start, num_checks=4; stim F0,AA,33,E7 each followed by responses 0F,55,CC,18 -> pass_cnt=4, fail_cnt=0, err=0, done=1.
REQ-044 num_checks=2; stim AA, AA; responses 55, 54 -> pass_cnt=1, fail_cnt=1, err=1, first_exp=55, first_got=54.
REQ-045 DEPTH=4; five stim with no resp -> ovf=1 on the fifth push; then push and pop together while full -> no further flag change, occupancy stays 4.
REQ-046 resp_valid with an empty FIFO, simultaneous with stim 0F -> udf=1, counters unchanged; the next resp F0 -> pass_cnt=1.
REQ-047 rst during RUN after 2 of 4 checks -> all outputs 0, IDLE; a later start with num_checks=1 completes normally.
REQ-048 num_checks=0 -> done=1 one cycle after start; start asserted while busy -> ignored.
